// File: rtl/sb_rx_deframer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sb_rx_deframer_if
// Description : Received-payload bundle from the sideband deframer: data,
//               framing strobes and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
interface sb_rx_deframer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_err;
  logic [1:0] err_code;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_sop,
    output rx_eop,
    output rx_err,
    output err_code
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_sop,
    input rx_eop,
    input rx_err,
    input err_code
  );
endinterface
`default_nettype wire

// File: rtl/sb_rx_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sb_rx_deframer
// Description : Serial sideband receiver: bit-level byte assembly, DLE/STX
//               frame hunting, DLE de-stuffing and one-deep payload release.
//               Optional CRC-16 check selected by macro SB_RX_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_rx_deframer #(
  parameter int MAX_LEN = 64
) (
  input  logic             sb_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sbrx,
  sb_rx_deframer_if.master rx
);

  localparam int               c_CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [7:0]       c_dle      = 8'hFE;
  localparam logic [7:0]       c_stx      = 8'h05;
  localparam logic [7:0]       c_etx      = 8'h40;
  localparam logic [1:0]       c_err_stop = 2'd0;
  localparam logic [1:0]       c_err_seq  = 2'd1;
  localparam logic [1:0]       c_err_ovf  = 2'd2;
  localparam logic [1:0]       c_err_crc  = 2'd3;
  localparam logic [c_CNT_W-1:0] c_max_cnt = c_CNT_W'(MAX_LEN);
  localparam logic [c_CNT_W-1:0] c_one     = c_CNT_W'(1);
`ifdef SB_RX_CRC_EN
  localparam logic [c_CNT_W-1:0] c_min_len = c_CNT_W'(3);
`else
  localparam logic [c_CNT_W-1:0] c_min_len = c_CNT_W'(1);
`endif

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_DATA = 2'd1,
    B_STOP = 2'd2
  } bit_state_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_DLE  = 2'd1,
    F_PAY  = 2'd2,
    F_ESC  = 2'd3
  } frame_state_e;

  bit_state_e   r_bstate;
  logic [2:0]   r_bitcnt;
  logic [7:0]   r_shift;
  logic         r_hold;
  logic         r_byte_rdy;
  logic         r_stop_err;

  frame_state_e r_fstate;
  logic [c_CNT_W-1:0] r_count;
  logic [7:0]   r_held;
  logic         r_held_vld;
  logic         r_first;

  logic         r_em_vld;
  logic [7:0]   r_em_data;
  logic         r_em_sop;
  logic         r_em_eop;
  logic         r_em_err;
  logic [1:0]   r_em_code;

  logic         w_stx;
  logic         w_pay;
  logic         w_etx;
  logic         w_seq;
  logic         w_ovf;
  logic         w_accept;
  logic         w_crc_bad;

  // Byte assembly; r_shift stays stable until the next start bit has been
  // sampled, which is after the frame stage has consumed it.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_bstate   <= B_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_hold     <= 1'b0;
      r_byte_rdy <= 1'b0;
      r_stop_err <= 1'b0;
    end else if (!enable) begin
      r_bstate   <= B_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_hold     <= 1'b0;
      r_byte_rdy <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_bstate)
        B_IDLE: begin
          if (!sbrx) begin
            r_bstate <= B_DATA;
            r_bitcnt <= 3'd0;
          end
        end
        B_DATA: begin
          r_shift  <= {sbrx, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_bstate <= B_STOP;
          end
        end
        B_STOP: begin
          if (r_hold) begin
            if (sbrx) begin
              r_hold   <= 1'b0;
              r_bstate <= B_IDLE;
            end
          end else if (sbrx) begin
            r_byte_rdy <= 1'b1;
            r_bstate   <= B_IDLE;
          end else begin
            r_stop_err <= 1'b1;
            r_hold     <= 1'b1;
          end
        end
        default: r_bstate <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stx = 1'b0;
    w_pay = 1'b0;
    w_etx = 1'b0;
    w_seq = 1'b0;
    if (r_byte_rdy) begin
      case (r_fstate)
        F_DLE: w_stx = (r_shift == c_stx);
        F_PAY: w_pay = (r_shift != c_dle);
        F_ESC: begin
          w_pay = (r_shift == c_dle);
          w_etx = (r_shift == c_etx);
          w_seq = (r_shift != c_dle) && (r_shift != c_etx);
        end
        default: ;
      endcase
    end
  end

  assign w_ovf    = w_pay && (r_count == c_max_cnt);
  assign w_accept = w_pay && !w_ovf;

`ifdef SB_RX_CRC_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_crc <= 16'hFFFF;
    end else if (!enable || w_stx) begin
      r_crc <= 16'hFFFF;
    end else if (w_accept) begin
      r_crc <= crc16_byte(r_crc, r_shift);
    end
  end

  // The trailing CRC bytes are folded in too, so a clean frame leaves zero.
  assign w_crc_bad = (r_crc != 16'h0000);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Frame stage: decides what the byte means and stages the output event.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_fstate   <= F_IDLE;
      r_count    <= '0;
      r_held     <= 8'h00;
      r_held_vld <= 1'b0;
      r_first    <= 1'b0;
      r_em_vld   <= 1'b0;
      r_em_data  <= 8'h00;
      r_em_sop   <= 1'b0;
      r_em_eop   <= 1'b0;
      r_em_err   <= 1'b0;
      r_em_code  <= 2'd0;
    end else if (!enable) begin
      r_fstate   <= F_IDLE;
      r_count    <= '0;
      r_held     <= 8'h00;
      r_held_vld <= 1'b0;
      r_first    <= 1'b0;
      r_em_vld   <= 1'b0;
      r_em_data  <= 8'h00;
      r_em_sop   <= 1'b0;
      r_em_eop   <= 1'b0;
      r_em_err   <= 1'b0;
      r_em_code  <= 2'd0;
    end else begin
      r_em_vld  <= 1'b0;
      r_em_sop  <= 1'b0;
      r_em_eop  <= 1'b0;
      r_em_err  <= 1'b0;
      r_em_code <= 2'd0;
      if (r_stop_err) begin
        r_fstate   <= F_IDLE;
        r_held_vld <= 1'b0;
        r_em_err   <= 1'b1;
        r_em_code  <= c_err_stop;
      end else if (r_byte_rdy) begin
        case (r_fstate)
          F_IDLE: begin
            if (r_shift == c_dle) r_fstate <= F_DLE;
          end
          F_DLE: begin
            if (w_stx) begin
              r_fstate   <= F_PAY;
              r_count    <= '0;
              r_held_vld <= 1'b0;
              r_first    <= 1'b1;
            end else if (r_shift != c_dle) begin
              r_fstate <= F_IDLE;
            end
          end
          F_PAY, F_ESC: begin
            if (w_ovf) begin
              r_fstate   <= F_IDLE;
              r_held_vld <= 1'b0;
              r_em_err   <= 1'b1;
              r_em_code  <= c_err_ovf;
            end else if (w_accept) begin
              r_fstate <= F_PAY;
              if (r_held_vld) begin
                r_em_vld  <= 1'b1;
                r_em_data <= r_held;
                r_em_sop  <= r_first;
                r_first   <= 1'b0;
              end
              r_held     <= r_shift;
              r_held_vld <= 1'b1;
              r_count    <= r_count + c_one;
            end else if (w_etx) begin
              r_fstate   <= F_IDLE;
              r_held_vld <= 1'b0;
              if (r_count < c_min_len) begin
                r_em_err  <= 1'b1;
                r_em_code <= c_err_seq;
              end else begin
                r_em_vld  <= 1'b1;
                r_em_data <= r_held;
                r_em_sop  <= r_first;
                r_em_eop  <= 1'b1;
                r_first   <= 1'b0;
                if (w_crc_bad) begin
                  r_em_err  <= 1'b1;
                  r_em_code <= c_err_crc;
                end
              end
            end else if (w_seq) begin
              r_fstate   <= F_IDLE;
              r_held_vld <= 1'b0;
              r_em_err   <= 1'b1;
              r_em_code  <= c_err_seq;
            end else begin
              r_fstate <= F_ESC;
            end
          end
          default: r_fstate <= F_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      rx.rx_sop   <= 1'b0;
      rx.rx_eop   <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.err_code <= 2'd0;
    end else if (!enable) begin
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      rx.rx_sop   <= 1'b0;
      rx.rx_eop   <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.err_code <= 2'd0;
    end else begin
      rx.rx_data  <= r_em_data;
      rx.rx_valid <= r_em_vld;
      rx.rx_sop   <= r_em_sop;
      rx.rx_eop   <= r_em_eop;
      rx.rx_err   <= r_em_err;
      rx.err_code <= r_em_code;
    end
  end

endmodule
`default_nettype wire

// File: doc/sb_rx_deframer.md
SB_RX_DEFRAMER -- requirements
Module: sb_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning the maximum number of de-stuffed payload bytes per frame.
REQ-002 SHALL have port sb_clk, input, 1 bit: sideband clock; one sbrx bit is sampled per rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1 bit: when low, the block is held idle.
REQ-005 SHALL have port sbrx, input, 1 bit: serial sideband receive line, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: de-stuffed payload byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port rx_sop, output, 1 bit: marks the first payload byte; valid only with rx_valid.
REQ-009 SHALL have port rx_eop, output, 1 bit: marks the last payload byte; valid only with rx_valid.
REQ-010 SHALL have port rx_err, output, 1 bit: one-cycle error strobe.
REQ-011 SHALL have port err_code, output, 2 bits: error cause, qualified by rx_err. 0=stop-bit, 1=sequence, 2=overflow, 3=CRC.

Function
REQ-012 Bit FSM states SHALL be B_IDLE, B_DATA and B_STOP.
REQ-013 In B_IDLE, sbrx=0 SHALL be taken as the start bit.
REQ-014 B_DATA SHALL sample 8 bits LSB-first, then move to B_STOP.
REQ-015 In B_STOP, sbrx=1 SHALL produce an internal byte_rdy pulse on the next cycle.
REQ-016 In B_STOP, sbrx=0 SHALL discard the byte, raise a stop-bit error, and hold the FSM until sbrx=1 before returning to B_IDLE.
REQ-017 Frame FSM states SHALL be F_IDLE, F_DLE, F_PAY and F_ESC.
REQ-018 F_IDLE SHALL move to F_DLE on byte 0xFE and ignore all other bytes.
REQ-019 F_DLE SHALL move to F_PAY on byte 0x05 (STX), stay in F_DLE on 0xFE, and go to F_IDLE on any other byte, with no error.
REQ-020 F_PAY SHALL move to F_ESC on byte 0xFE; any other byte SHALL be a payload byte.
REQ-021 F_ESC on 0xFE SHALL produce payload byte 0xFE and return to F_PAY.
REQ-022 F_ESC on 0x40 (ETX) SHALL end the frame and return to F_IDLE.
REQ-023 F_ESC on any other byte SHALL raise a sequence error and go to F_IDLE.
REQ-024 Payload bytes SHALL be held one deep: a byte is emitted when the next payload byte arrives, or with rx_eop=1 when ETX arrives.
REQ-025 rx_valid SHALL assert exactly 2 sb_clk cycles after the edge sampling the stop bit of the releasing byte.
REQ-026 rx_sop SHALL assert with the first emitted byte of each frame.
REQ-027 A frame ending on ETX with zero payload bytes SHALL raise a sequence error and emit nothing.
REQ-028 A payload byte arriving when the count already equals MAX_LEN SHALL raise an overflow error and move the FSM to F_IDLE.
REQ-029 On any error in F_PAY or F_ESC, the held byte SHALL be dropped and no rx_eop emitted; the consumer discards the partial frame.
REQ-030 rx_err SHALL pulse in the cycle in which the held byte would otherwise have been emitted.
REQ-031 When rx_err coincides with rx_valid (CRC case only), both SHALL assert in the same cycle.
REQ-032 A stop-bit error in F_IDLE or F_DLE SHALL be reported and SHALL return the frame FSM to F_IDLE.
REQ-033 enable=0 SHALL synchronously force both FSMs idle, clear the byte count and held byte, and drive outputs low.
REQ-034 A frame already in progress when enable rises SHALL be ignored until the next DLE STX.

Reset
REQ-035 rst=0 SHALL asynchronously clear all state, setting B_IDLE and F_IDLE.
REQ-036 rst=0 SHALL clear rx_data=0x00, rx_valid=0, rx_sop=0, rx_eop=0, rx_err=0 and err_code=0.
REQ-037 Assertion of rst mid-frame SHALL discard the frame with no error.

Configuration
REQ-038 Macro SB_RX_CRC_EN SHALL select CRC checking.
REQ-039 With SB_RX_CRC_EN defined: CRC-16 (poly 0x8005, init 0xFFFF, MSB-first, no reflection, no final XOR) SHALL be computed over all de-stuffed payload bytes, including the 2 trailing CRC bytes (high byte first).
REQ-040 With SB_RX_CRC_EN defined: a non-zero residue at ETX SHALL give rx_err=1 with err_code=3, together with the rx_eop byte.
REQ-041 With SB_RX_CRC_EN defined: a payload shorter than 3 bytes SHALL give a sequence error.
REQ-042 Without SB_RX_CRC_EN: no CRC logic SHALL exist; CRC bytes are ordinary payload and err_code=3 is never produced.

Verification
REQ-043 Bytes FE 05 11 22 FE 40 -> rx_valid twice: 0x11 with sop, then 0x22 with eop; no rx_err.
REQ-044 Bytes FE 05 FE FE 33 FE 40 -> payload 0xFE (sop), 0x33 (eop).
REQ-045 Bytes FE 05 AA FE 07 -> rx_err with err_code=1; 0xAA never emitted.
REQ-046 0x55 sent with stop bit 0 inside a frame -> rx_err with err_code=0; no eop; next FE 05 01 FE 40 received normally.
REQ-047 MAX_LEN=4; frame of 5 payload bytes -> bytes 1-3 emitted, rx_err with err_code=2, no eop.
REQ-048 SB_RX_CRC_EN; payload 01 02 with correct CRC appended, then the same frame with one CRC bit flipped -> first frame: eop with no err; second frame: eop with err_code=3; rst=0 mid-frame -> all outputs 0 immediately.
